// File: rtl/eth_rx_slot_writer_pkg.sv
// Shared definitions for the Ethernet RX slot writer: address split, FSM
// state encoding and the per-frame completion record.
package eth_rx_slot_writer_pkg;

    localparam int unsigned SLOT_W        = 3;
    localparam int unsigned ADDR_W        = 13;
    localparam int unsigned LEN_W         = 11;
    localparam int unsigned MAX_BYTES_DEF = 1536;
    localparam int unsigned HW_W          = ADDR_W - SLOT_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECV   = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_RECV   = ST_RECV,
        S_DROP   = ST_DROP,
        S_COMMIT = ST_COMMIT
    } eth_rx_wr_state_e;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [LEN_W-1:0]  len;
        logic              err;
    } eth_rx_done_t;

endpackage

// File: rtl/eth_rx_slot_writer_slot_ring.sv
// Slot ring: next write slot and occupancy count, arbitrating frame commits
// against software releases.
module eth_slot_ring
    import eth_rx_slot_writer_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              commit_i,
    input  logic              release_i,
    output logic [SLOT_W-1:0] wr_slot_o,
    output logic [3:0]        slots_used_o,
    output logic              full_o
);

    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [3:0]        used_q, used_d;
    logic              rel_ok;

    // A release against an empty ring is dropped; commit+release cancel out.
    assign rel_ok = release_i && (used_q != '0);

    always_comb begin
        wr_slot_d = wr_slot_q;
        used_d    = used_q;
        if (commit_i) begin
            wr_slot_d = wr_slot_q + SLOT_W'(1);
        end
        unique case ({commit_i, rel_ok})
            2'b10:   used_d = used_q + 4'd1;
            2'b01:   used_d = used_q - 4'd1;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_slot_q <= '0;
            used_q    <= '0;
        end else begin
            wr_slot_q <= wr_slot_d;
            used_q    <= used_d;
        end
    end

    assign wr_slot_o    = wr_slot_q;
    assign slots_used_o = used_q;
    assign full_o       = (used_q == 4'(NUM_SLOTS));

endmodule

// File: rtl/eth_rx_slot_writer.sv
// Ethernet RX write stage: streams MAC bytes into 2 KiB slots of the frame
// memory and emits one completion record per stored frame.
module eth_rx_slot_writer
    import eth_rx_slot_writer_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    input  logic        rx_err_i,
    output logic        rx_ready_o,
    output logic [12:0] mem_addr_o,
    output logic [15:0] mem_din_o,
    output logic [1:0]  mem_we_o,
    output logic        mem_en_o,
    output logic        done_valid_o,
    input  logic        done_ready_i,
    output logic [2:0]  done_slot_o,
    output logic [10:0] done_len_o,
    output logic        done_err_o,
    input  logic        release_i,
    output logic [3:0]  slots_used_o,
    output logic [15:0] drop_cnt_o
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    eth_rx_wr_state_e  state_q, state_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic [1:0]        we_q, we_d;
    eth_rx_done_t      done_q, done_d;
    logic [15:0]       drop_q, drop_d;
    logic [LEN_W-1:0]  len_nx;
    logic              err_nx;
    logic [SLOT_W-1:0] wr_slot;
    logic              full;
    logic              accept;
    logic              commit;

    assign rx_ready_o = (state_q != S_COMMIT);
    assign accept     = rx_valid_i && rx_ready_o;
    assign commit     = (state_q == S_COMMIT) && done_ready_i;

    eth_slot_ring #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_ring (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .commit_i    (commit),
        .release_i   (release_i),
        .wr_slot_o   (wr_slot),
        .slots_used_o(slots_used_o),
        .full_o      (full)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = '0;
        done_d  = done_q;
        drop_d  = drop_q;
        len_nx  = count_q;
        err_nx  = err_q | rx_err_i;
        unique case (state_q)
            S_IDLE: begin
                if (accept && !full) begin
                    addr_d  = {wr_slot, {HW_W{1'b0}}};
                    din_d   = {rx_data_i, rx_data_i};
                    we_d    = 2'b01;
                    count_d = LEN_W'(1);
                    err_d   = rx_err_i;
                    if (rx_last_i) begin
                        state_d     = S_COMMIT;
                        done_d.slot = wr_slot;
                        done_d.len  = LEN_W'(1);
                        done_d.err  = rx_err_i;
                    end else begin
                        state_d = S_RECV;
                    end
                end else if (accept) begin
                    if (drop_q != '1) begin
                        drop_d = drop_q + 16'd1;
                    end
                    if (!rx_last_i) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    // Bytes past the slot capacity are discarded but flag the frame.
                    if (count_q < MAX_LEN) begin
                        addr_d = {wr_slot, count_q[LEN_W-1:1]};
                        din_d  = {rx_data_i, rx_data_i};
                        we_d   = count_q[0] ? 2'b10 : 2'b01;
                        len_nx = count_q + LEN_W'(1);
                    end else begin
                        err_nx = 1'b1;
                    end
                    count_d = len_nx;
                    err_d   = err_nx;
                    if (rx_last_i) begin
                        state_d     = S_COMMIT;
                        done_d.slot = wr_slot;
                        done_d.len  = len_nx;
                        done_d.err  = err_nx;
                    end
                end
            end
            S_DROP: begin
                if (accept && rx_last_i) begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                if (done_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= '0;
            done_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_din_o    = din_q;
    assign mem_we_o     = we_q;
    assign mem_en_o     = |we_q;
    assign done_valid_o = (state_q == S_COMMIT);
    assign done_slot_o  = done_q.slot;
    assign done_len_o   = done_q.len;
    assign done_err_o   = done_q.err;
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_eth_rx_slot_writer.sv
// Self-checking bench for eth_rx_slot_writer: random frame payloads checked
// against a slot/occupancy reference model and a captured image of memory.
module tb_eth_rx_slot_writer;

    localparam int MAXB = 1536;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_last, rx_err;
    logic        rx_ready;
    logic [12:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_en;
    logic        done_valid, done_ready;
    logic [2:0]  done_slot;
    logic [10:0] done_len;
    logic        done_err;
    logic        rel;
    logic [3:0]  slots_used;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    eth_rx_slot_writer #(.NUM_SLOTS(8), .MAX_BYTES(MAXB)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_last_i(rx_last), .rx_err_i(rx_err),
        .rx_ready_o(rx_ready),
        .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_we_o(mem_we), .mem_en_o(mem_en),
        .done_valid_o(done_valid), .done_ready_i(done_ready),
        .done_slot_o(done_slot), .done_len_o(done_len), .done_err_o(done_err),
        .release_i(rel), .slots_used_o(slots_used), .drop_cnt_o(drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_used = 0;
    int m_wr   = 0;
    int m_drop = 0;

    // Memory image rebuilt from observed writes
    logic [7:0]  cap [0:16383];
    logic [7:0]  fb  [0:1599];
    int          wr_total = 0;
    int          en_bad   = 0;
    logic [12:0] last_addr = '0;
    logic [1:0]  last_we   = '0;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (mem_we[0]) begin cap[{mem_addr, 1'b0}] = mem_din[7:0];  wr_total++; end
            if (mem_we[1]) begin cap[{mem_addr, 1'b1}] = mem_din[15:8]; wr_total++; end
            if (mem_en !== (|mem_we)) en_bad++;
            if (mem_we != 2'b00) begin last_addr = mem_addr; last_we = mem_we; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
        chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
        chk({tag, "_mem_en"},     32'(mem_en),     32'd0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        chk({tag, "_mem_din"},    32'(mem_din),    32'd0);
        chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
        chk({tag, "_done_slot"},  32'(done_slot),  32'd0);
        chk({tag, "_done_len"},   32'(done_len),   32'd0);
        chk({tag, "_done_err"},   32'(done_err),   32'd0);
        chk({tag, "_slots_used"}, 32'(slots_used), 32'd0);
        chk({tag, "_drop_cnt"},   32'(drop_cnt),   32'd0);
    endtask

    task automatic send_frame(input int n, input int errpos, input bit with_last);
        int guard;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = fb[i];
            rx_last  = with_last && (i == n - 1);
            rx_err   = (i == errpos);
            guard = 0;
            while (!rx_ready) begin
                @(negedge clk);
                guard++;
                if (guard > 50) begin
                    errors++;
                    $display("FAIL rx_ready_timeout observed=0 expected=1");
                    $fatal(1, "rx_ready never asserted");
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic do_release();
        @(negedge clk);
        rel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rel = 1'b0;
        #1;
        if (m_used > 0) m_used--;
        chk("release_used", 32'(slots_used), 32'(m_used));
    endtask

    task automatic run_frame(input int n, input int errpos, input bit rel_hs, input string tag);
        int start, stored, mism, guard;
        bit drop, exp_err;
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
        drop = (m_used == 8);
        if (!drop) for (int i = 0; i < 2048; i++) cap[m_wr * 2048 + i] = 'x;
        start = wr_total;
        send_frame(n, errpos, 1'b1);
        if (drop) begin
            @(negedge clk);
            #1;
            if (m_drop < 65535) m_drop++;
            chk({tag, "_drop_writes"}, 32'(wr_total - start), 32'd0);
            chk({tag, "_drop_cnt"},    32'(drop_cnt),         32'(m_drop));
            chk({tag, "_drop_norec"},  32'(done_valid),       32'd0);
            chk({tag, "_drop_ready"},  32'(rx_ready),         32'd1);
        end else begin
            stored  = (n > MAXB) ? MAXB : n;
            exp_err = (errpos >= 0 && errpos < n) || (n > MAXB);
            guard = 0;
            do begin
                @(negedge clk);
                #1;
                guard++;
            end while (!done_valid && guard < 20);
            chk({tag, "_done_valid"}, 32'(done_valid), 32'd1);
            chk({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
            chk({tag, "_slot"},       32'(done_slot),  32'(m_wr));
            chk({tag, "_len"},        32'(done_len),   32'(stored));
            chk({tag, "_err"},        32'(done_err),   32'(exp_err));
            chk({tag, "_writes"},     32'(wr_total - start), 32'(stored));
            mism = 0;
            for (int i = 0; i < stored; i++)
                if (cap[m_wr * 2048 + i] !== fb[i]) mism++;
            chk({tag, "_data"}, 32'(mism), 32'd0);
            @(negedge clk);
            done_ready = 1'b1;
            rel        = rel_hs;
            @(posedge clk);
            @(negedge clk);
            done_ready = 1'b0;
            rel        = 1'b0;
            #1;
            if (!rel_hs) m_used++;
            m_wr = (m_wr + 1) % 8;
            chk({tag, "_used_after"},  32'(slots_used), 32'(m_used));
            chk({tag, "_valid_after"}, 32'(done_valid), 32'd0);
        end
    endtask

    initial begin
        rst_ni = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
        done_ready = 1'b0; rel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_ni = 1'b1;

        run_frame(60, -1, 1'b0, "f60");
        chk("f60_last_addr", 32'(last_addr), 32'd29);
        chk("f60_last_we",   32'(last_we),   32'b10);

        run_frame(30, -1, 1'b0, "f30");
        run_frame(61, -1, 1'b0, "f61");
        chk("f61_last_addr", 32'(last_addr), 32'h81E);
        chk("f61_last_we",   32'(last_we),   32'b01);

        repeat (3) do_release();
        do_release();
        chk("rel_at_zero", 32'(slots_used), 32'd0);

        for (int i = 0; i < 20; i++) fb[i] = 8'($urandom);
        send_frame(20, -1, 1'b0);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_ni = 1'b1;
        m_used = 0; m_wr = 0; m_drop = 0;

        for (int k = 0; k < 9; k++) run_frame(40 + k, -1, 1'b0, "fill");
        run_frame(1, -1, 1'b0, "drop1");
        do_release();
        run_frame(50, -1, 1'b1, "f10_relhs");

        repeat (4) do_release();
        run_frame(1600, -1, 1'b0, "over");
        run_frame(64, 10, 1'b0, "macerr");

        for (int k = 0; k < 14; k++) begin
            int n, ep;
            bit rh;
            n  = int'($urandom_range(1, 300));
            ep = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            rh = (m_used > 0) && ($urandom_range(0, 3) == 0);
            run_frame(n, ep, rh, "rnd");
            if ($urandom_range(0, 2) == 0) do_release();
        end

        chk("mem_en_vs_we", 32'(en_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_slot_writer.md
# eth_rx_slot_writer

Upstream write stage of the Ethernet RX buffer. Accepts the MAC's received byte stream and writes each frame into one of eight 2 KiB slots of the 16-bit-wide write port of the dual-port RX frame memory. Tracks slot occupancy against software releases, drops frames when no slot is free, and hands a per-frame completion record (slot, length, error) to the descriptor/interrupt logic.

## Interface
- NUM_SLOTS, 8: frame slots; fixed at 8 by the 13-bit address split, slot = addr[12:10].
- MAX_BYTES, 1536: bytes stored per frame; further bytes set the error flag and are discarded.
- clk_i  in  1  single clock; the memory write port is clocked from the same net.
- rst_ni  in  1  asynchronous, active-low reset.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  byte valid.
- rx_last_i  in  1  final byte of frame; qualified by rx_valid_i.
- rx_err_i  in  1  MAC error (FCS/symbol) on this byte; qualified by rx_valid_i.
- rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o.
- mem_addr_o  out  13  write address, {slot[2:0], halfword[9:0]}.
- mem_din_o  out  16  {byte, byte}.
- mem_we_o  out  2  byte write enables: 2'b01 even byte, 2'b10 odd byte.
- mem_en_o  out  1  memory enable; equals |mem_we_o.
- done_valid_o  out  1  completion record valid.
- done_ready_i  in  1  completion record consumed.
- done_slot_o  out  3  slot holding the frame.
- done_len_o  out  11  stored byte count, 1..MAX_BYTES.
- done_err_o  out  1  MAC error seen or oversize.
- release_i  in  1  one-cycle pulse: software frees the oldest occupied slot.
- slots_used_o  out  4  occupied slot count, 0..8.
- drop_cnt_o  out  16  frames dropped for lack of a slot; saturates at 16'hFFFF.

## Operation
- Four-state FSM: IDLE, RECV, DROP, COMMIT.
- IDLE: on an accepted byte with slots_used < 8, write it at byte offset 0 of wr_slot and enter RECV, or COMMIT if rx_last_i is also set. With slots_used == 8, increment drop_cnt and enter DROP; a single-byte frame (rx_last_i set) is counted and stays in IDLE.
- RECV: each accepted byte with byte count < MAX_BYTES is written at offset = count, and count increments. A byte with count == MAX_BYTES is not written and sets err. rx_err_i sets err. On rx_last_i go to COMMIT.
- DROP: accept and discard bytes with no writes. On rx_last_i return to IDLE.
- COMMIT: rx_ready_o = 0. done_valid_o = 1 with a stable record. On done_ready_i: wr_slot increments mod 8, slots_used increments, and the FSM returns to IDLE.
- Address: halfword = count[10:1]; we = count[0] ? 2'b10 : 2'b01.
- release_i: slots_used decrements. A release with slots_used == 0 is ignored. A release in the same cycle as a COMMIT handshake leaves slots_used unchanged.
- Oversize frames still commit, with done_len_o = MAX_BYTES and done_err_o = 1.

## Timing
- rx_ready_o is combinational from state: 1 in IDLE, RECV and DROP; 0 in COMMIT.
- Memory write outputs are registered, one cycle after byte acceptance. Byte n is written exactly once.
- done_* outputs are registered and valid from the first COMMIT cycle, which is the cycle after the last byte is accepted. The last byte's write has completed by the cycle done_valid_o rises.
- Minimum inter-frame gap is one cycle: the cycle after the handshake accepts a new frame.
- Reset values: state IDLE, rx_ready_o 1, mem_we_o 0, mem_en_o 0, mem_addr_o 0, mem_din_o 0, done_valid_o 0, done_slot_o 0, done_len_o 0, done_err_o 0, slots_used_o 0, drop_cnt_o 0, wr_slot 0.
- Reset mid-frame: the partial frame is abandoned, with no completion record and no slot consumed. The MAC resynchronises on the next frame start.

## Structure
- The shared Ethernet package holds:
  - SLOT_W = 3, ADDR_W = 13, LEN_W = 11, MAX_BYTES_DEF = 1536;
  - the FSM state enum eth_rx_wr_state_e;
  - the packed struct eth_rx_done_t {slot, len, err}.
- One sub-module, eth_slot_ring: owns wr_slot, slots_used, and the commit/release arbitration, including the simultaneous and underflow cases. The writer FSM stays in the top.

## Test plan
- 60-byte clean frame after reset:
  - 60 writes to addresses 0..29 with alternating we 01/10;
  - done record {slot 0, len 60, err 0};
  - slots_used 1 after the handshake.
- 61-byte frame into slot 2:
  - last write at addr 0x81E, we 01;
  - len 61.
- Nine back-to-back frames with no releases:
  - frames 1–8 fill slots 0..7;
  - frame 9 gets no writes and drop_cnt becomes 1;
  - after one release_i, frame 10 goes to slot 0.
- 1600-byte frame:
  - exactly 1536 writes;
  - record {len 1536, err 1}.
- rx_err_i pulsed on byte 10 of a 64-byte frame: all 64 bytes written; err 1.
- Edge cases:
  - release_i coinciding with the COMMIT handshake leaves slots_used unchanged;
  - release_i at slots_used 0 is ignored;
  - rst_ni low mid-frame leaves all outputs at reset values, and a new frame lands in slot 0.
